// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between the two bus-side masters and alu_share_arbiter.
// The master modport is the requester side and the slave modport is the arbiter side.
interface alu_share_arbiter_if;
  logic        req0;
  logic [1:0]  op0;
  logic [31:0] a0;
  logic [31:0] b0;
  logic        req1;
  logic [1:0]  op1;
  logic [31:0] a1;
  logic [31:0] b1;
  logic        ack0;
  logic        ack1;
  logic [31:0] result;
  logic        gnt_id;
  logic        busy;

  modport master (
    output req0, op0, a0, b0, req1, op1, a1, b1,
    input  ack0, ack1, result, gnt_id, busy
  );

  modport slave (
    input  req0, op0, a0, b0, req1, op1, a1, b1,
    output ack0, ack1, result, gnt_id, busy
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Two-requester arbiter/sequencer for the shared 32-bit ALU: grant, latch, execute, one-cycle ack.
// Build option ALU_ARB_ROUND_ROBIN_EN selects round-robin tie-break; otherwise requester 0 wins ties.
module alu_share_arbiter (
  input logic                clk,
  input logic                rst_n,
  alu_share_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        take;
  logic        sel;
  logic        tie_winner;
  logic [1:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] alu_out;
  logic [31:0] result_q;
  logic        gnt_q;
  logic        ack0_q;
  logic        ack1_q;

`ifdef ALU_ARB_ROUND_ROBIN_EN
  // Remembers the last winner; resets to 1 so requester 0 takes the first tie.
  logic last_gnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt <= 1'b1;
    end else if (take) begin
      last_gnt <= sel;
    end
  end

  assign tie_winner = ~last_gnt;
`else
  assign tie_winner = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Requests are only looked at in IDLE; EXEC and DONE always advance.
  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    sel       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          take      = 1'b1;
          state_nxt = EXEC;
          sel       = (bus.req0 && bus.req1) ? tie_winner : bus.req1;
        end
      end
      EXEC:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    alu_out = 32'd0;
    case (op_q)
      2'b00:   alu_out = a_q & b_q;
      2'b01:   alu_out = a_q | b_q;
      2'b10:   alu_out = a_q + b_q;
      default: alu_out = a_q ^ b_q;
    endcase
  end

  // Operands are captured on the grant edge so later bus changes cannot disturb the operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= 2'b00;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      gnt_q    <= 1'b0;
      result_q <= 32'd0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      if (take) begin
        op_q  <= sel ? bus.op1 : bus.op0;
        a_q   <= sel ? bus.a1  : bus.a0;
        b_q   <= sel ? bus.b1  : bus.b0;
        gnt_q <= sel;
      end
      if (state == EXEC) begin
        result_q <= alu_out;
        ack0_q   <= ~gnt_q;
        ack1_q   <= gnt_q;
      end
    end
  end

  assign bus.ack0   = ack0_q;
  assign bus.ack1   = ack1_q;
  assign bus.result = result_q;
  assign bus.gnt_id = gnt_q;
  assign bus.busy   = (state != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed scenarios plus randomized operations
// checked against a behavioural model (honours ALU_ARB_ROUND_ROBIN_EN for tie handling).
module tb_alu_share_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  logic ref_last;

`ifdef ALU_ARB_ROUND_ROBIN_EN
  localparam bit TIE_RR = 1'b1;
`else
  localparam bit TIE_RR = 1'b0;
`endif

  alu_share_arbiter_if bus ();

  alu_share_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_alu(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a + b;
      default: return a ^ b;
    endcase
  endfunction

  // Winner chosen by the arbitration rule for the given request lines and previous winner.
  function automatic logic ref_pick(input logic r0, input logic r1, input logic last);
    if (r0 && r1) return TIE_RR ? ~last : 1'b0;
    return r1;
  endfunction

  task automatic applyStimulus(input logic r0, input logic [1:0] o0, input logic [31:0] x0, input logic [31:0] y0,
                               input logic r1, input logic [1:0] o1, input logic [31:0] x1, input logic [31:0] y1);
    bus.req0 = r0; bus.op0 = o0; bus.a0 = x0; bus.b0 = y0;
    bus.req1 = r1; bus.op1 = o1; bus.a1 = x1; bus.b1 = y1;
  endtask

  // Counts falling edges until an ack is seen; gives up after 8.
  task automatic wait_ack(output int n);
    n = 0;
    while (n < 8) begin
      @(negedge clk);
      n++;
      if (bus.ack0 || bus.ack1) break;
    end
  endtask

  task automatic test_reset();
    applyStimulus(1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 2'd0, 32'd0, 32'd0);
    rst_n = 1'b0;
    ref_last = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.ack1, bus.ack0} !== 2'b00) begin
      errors++; $display("[TB] FAIL reset_ack: got %b expected 00", {bus.ack1, bus.ack0});
    end
    checks++;
    if (bus.result !== 32'd0) begin
      errors++; $display("[TB] FAIL reset_result: got %0h expected 0", bus.result);
    end
    checks++;
    if (bus.gnt_id !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_gnt: got %b expected 0", bus.gnt_id);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [31:0] held;
    applyStimulus(1'b1, 2'd0, 32'd10, 32'd6, 1'b0, 2'd0, 32'd0, 32'd0);
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1 || bus.ack0 !== 1'b0) begin
      errors++; $display("[TB] FAIL basic_exec: got busy=%b ack0=%b expected busy=1 ack0=0", bus.busy, bus.ack0);
    end
    @(negedge clk);
    checks++;
    if ({bus.ack1, bus.ack0} !== 2'b01) begin
      errors++; $display("[TB] FAIL basic_ack: got %b expected 01", {bus.ack1, bus.ack0});
    end
    checks++;
    if (bus.result !== ref_alu(2'd0, 32'd10, 32'd6)) begin
      errors++; $display("[TB] FAIL basic_result: got %0h expected %0h", bus.result, ref_alu(2'd0, 32'd10, 32'd6));
    end
    checks++;
    if (bus.gnt_id !== 1'b0) begin
      errors++; $display("[TB] FAIL basic_gnt: got %b expected 0", bus.gnt_id);
    end
    ref_last = 1'b0;
    held = bus.result;
    applyStimulus(1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 2'd0, 32'd0, 32'd0);
    @(negedge clk);
    checks++;
    if (bus.ack0 !== 1'b0 || bus.busy !== 1'b0 || bus.result !== held) begin
      errors++; $display("[TB] FAIL basic_done: got ack0=%b busy=%b result=%0h expected 0 0 %0h",
                         bus.ack0, bus.busy, bus.result, held);
    end
  endtask

  task automatic test_req1_ops();
    logic [1:0]  ov[3];
    logic [31:0] av[3];
    logic [31:0] bv[3];
    int n;
    ov[0] = 2'd2; av[0] = 32'hFFFF_FFFF; bv[0] = 32'd1;
    ov[1] = 2'd1; av[1] = 32'd5;         bv[1] = 32'd9;
    ov[2] = 2'd3; av[2] = 32'd10;        bv[2] = 32'd10;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 2'd0, 32'd0, 32'd0, 1'b1, ov[i], av[i], bv[i]);
      wait_ack(n);
      checks++;
      if (n !== 2) begin
        errors++; $display("[TB] FAIL req1_latency[%0d]: got %0d edges expected 2", i, n);
      end
      checks++;
      if ({bus.ack1, bus.ack0} !== 2'b10 || bus.gnt_id !== 1'b1) begin
        errors++; $display("[TB] FAIL req1_ack[%0d]: got acks=%b gnt=%b expected 10 1", i, {bus.ack1, bus.ack0}, bus.gnt_id);
      end
      checks++;
      if (bus.result !== ref_alu(ov[i], av[i], bv[i])) begin
        errors++; $display("[TB] FAIL req1_result[%0d]: got %0h expected %0h", i, bus.result, ref_alu(ov[i], av[i], bv[i]));
      end
      ref_last = 1'b1;
      applyStimulus(1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 2'd0, 32'd0, 32'd0);
      @(negedge clk);
    end
  endtask

  task automatic test_tie();
    int   n;
    logic exp_id;
    logic [31:0] exp_res;
    applyStimulus(1'b1, 2'd0, 32'd2, 32'd3, 1'b1, 2'd2, 32'd1, 32'd3);
    for (int k = 0; k < 4; k++) begin
      wait_ack(n);
      exp_id  = ref_pick(1'b1, 1'b1, ref_last);
      exp_res = exp_id ? ref_alu(2'd2, 32'd1, 32'd3) : ref_alu(2'd0, 32'd2, 32'd3);
      checks++;
      if (n !== ((k == 0) ? 2 : 3)) begin
        errors++; $display("[TB] FAIL tie_spacing[%0d]: got %0d edges expected %0d", k, n, (k == 0) ? 2 : 3);
      end
      checks++;
      if (bus.gnt_id !== exp_id || {bus.ack1, bus.ack0} !== (exp_id ? 2'b10 : 2'b01)) begin
        errors++; $display("[TB] FAIL tie_grant[%0d]: got gnt=%b acks=%b expected gnt=%b", k, bus.gnt_id, {bus.ack1, bus.ack0}, exp_id);
      end
      checks++;
      if (bus.result !== exp_res) begin
        errors++; $display("[TB] FAIL tie_result[%0d]: got %0h expected %0h", k, bus.result, exp_res);
      end
      ref_last = exp_id;
    end
    applyStimulus(1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 2'd0, 32'd0, 32'd0);
    @(negedge clk);
  endtask

  task automatic test_operand_change();
    int n;
    applyStimulus(1'b1, 2'd0, 32'd6, 32'd2, 1'b0, 2'd0, 32'd0, 32'd0);
    @(negedge clk);
    bus.a0 = 32'd0;
    wait_ack(n);
    checks++;
    if (n !== 1 || bus.ack0 !== 1'b1) begin
      errors++; $display("[TB] FAIL opchg_ack: got %0d edges ack0=%b expected 1 1", n, bus.ack0);
    end
    checks++;
    if (bus.result !== ref_alu(2'd0, 32'd6, 32'd2)) begin
      errors++; $display("[TB] FAIL opchg_result: got %0h expected %0h", bus.result, ref_alu(2'd0, 32'd6, 32'd2));
    end
    ref_last = 1'b0;
    applyStimulus(1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 2'd0, 32'd0, 32'd0);
    @(negedge clk);
  endtask

  task automatic test_reset_exec();
    int n;
    applyStimulus(1'b1, 2'd2, 32'd7, 32'd8, 1'b0, 2'd0, 32'd0, 32'd0);
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++; $display("[TB] FAIL rstexec_busy_pre: got %b expected 1", bus.busy);
    end
    rst_n = 1'b0;
    ref_last = 1'b1;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.result !== 32'd0 || bus.ack0 !== 1'b0) begin
      errors++; $display("[TB] FAIL rstexec_async: got busy=%b result=%0h ack0=%b expected 0 0 0", bus.busy, bus.result, bus.ack0);
    end
    applyStimulus(1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 2'd0, 32'd0, 32'd0);
    repeat (2) @(negedge clk);
    checks++;
    if (bus.ack0 !== 1'b0) begin
      errors++; $display("[TB] FAIL rstexec_noack: got %b expected 0", bus.ack0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(1'b1, 2'd0, 32'h0000_F0F0, 32'h0000_FF00, 1'b0, 2'd0, 32'd0, 32'd0);
    wait_ack(n);
    checks++;
    if (n !== 2 || bus.ack0 !== 1'b1 || bus.result !== ref_alu(2'd0, 32'h0000_F0F0, 32'h0000_FF00)) begin
      errors++; $display("[TB] FAIL rstexec_after: got %0d edges ack0=%b result=%0h expected 2 1 %0h",
                         n, bus.ack0, bus.result, ref_alu(2'd0, 32'h0000_F0F0, 32'h0000_FF00));
    end
    ref_last = 1'b0;
    applyStimulus(1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 2'd0, 32'd0, 32'd0);
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int n;
    applyStimulus(1'b1, 2'd1, 32'd5, 32'd9, 1'b0, 2'd0, 32'd0, 32'd0);
    @(negedge clk);
    bus.req1 = 1'b1; bus.op1 = 2'd2; bus.a1 = 32'd100; bus.b1 = 32'd23;
    wait_ack(n);
    checks++;
    if (n !== 1 || {bus.ack1, bus.ack0} !== 2'b01) begin
      errors++; $display("[TB] FAIL b2b_first: got %0d edges acks=%b expected 1 01", n, {bus.ack1, bus.ack0});
    end
    ref_last = 1'b0;
    bus.req0 = 1'b0;
    wait_ack(n);
    checks++;
    if (n !== 3 || {bus.ack1, bus.ack0} !== 2'b10 || bus.gnt_id !== 1'b1) begin
      errors++; $display("[TB] FAIL b2b_second: got %0d edges acks=%b gnt=%b expected 3 10 1", n, {bus.ack1, bus.ack0}, bus.gnt_id);
    end
    checks++;
    if (bus.result !== ref_alu(2'd2, 32'd100, 32'd23)) begin
      errors++; $display("[TB] FAIL b2b_result: got %0h expected %0h", bus.result, ref_alu(2'd2, 32'd100, 32'd23));
    end
    ref_last = 1'b1;
    applyStimulus(1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 2'd0, 32'd0, 32'd0);
    @(negedge clk);
  endtask

  task automatic test_random();
    int          n;
    logic [1:0]  pat;
    logic [1:0]  o0, o1;
    logic [31:0] x0, y0, x1, y1, exp_res;
    logic        exp_id;
    for (int i = 0; i < 24; i++) begin
      pat = 2'($urandom_range(1, 3));
      o0 = 2'($urandom_range(0, 3)); x0 = $urandom; y0 = $urandom;
      o1 = 2'($urandom_range(0, 3)); x1 = $urandom; y1 = $urandom;
      applyStimulus(pat[0], o0, x0, y0, pat[1], o1, x1, y1);
      exp_id  = ref_pick(pat[0], pat[1], ref_last);
      exp_res = exp_id ? ref_alu(o1, x1, y1) : ref_alu(o0, x0, y0);
      wait_ack(n);
      checks++;
      if (n !== 2 || bus.gnt_id !== exp_id || {bus.ack1, bus.ack0} !== (exp_id ? 2'b10 : 2'b01)) begin
        errors++; $display("[TB] FAIL rand_grant[%0d]: got %0d edges gnt=%b acks=%b expected 2 gnt=%b",
                           i, n, bus.gnt_id, {bus.ack1, bus.ack0}, exp_id);
      end
      checks++;
      if (bus.result !== exp_res) begin
        errors++; $display("[TB] FAIL rand_result[%0d]: got %0h expected %0h", i, bus.result, exp_res);
      end
      ref_last = exp_id;
      applyStimulus(1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 2'd0, 32'd0, 32'd0);
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    ref_last = 1'b1;
    test_reset();
    test_basic();
    test_req1_ops();
    test_tie();
    test_operand_change();
    test_reset_exec();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
